sum_stationary_ctrl: RTL

//  Job sequencer wrapped around one sum_stationary NxN systolic array.
//  - Accepts one operand pair per beat over a valid/ready stream and drives the array's inputs.
//  - Clears the array before every job and waits for the array's result-valid.
//  - Returns the NxN product as N row beats over a valid/ready output stream.
//  - Gives up the job if the array never produces a result-valid.

---
 rtl/sum_stationary_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sum_stationary_ctrl.sv
// Job sequencer around one NxN sum-stationary array: clear, feed N operand beats, drain, emit N result rows.
// Inputs pass straight to the array in FEED; rows come straight from the array in OUT and hold while out_ready_i is low.
module sum_stationary_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int N             = 4,
  parameter int C_DATA_WIDTH  = 2*DATA_WIDTH + $clog2(N),
  parameter int DRAIN_TIMEOUT = 2*N + 2
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_a_i [N],
  input  logic [DATA_WIDTH-1:0]   in_b_i [N],
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [C_DATA_WIDTH-1:0] out_row_o [N],
  output logic [$clog2(N)-1:0]    out_idx_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o,
  output logic                    arr_reset_o,
  output logic                    arr_valid_o,
  output logic [DATA_WIDTH-1:0]   arr_a_o [N],
  output logic [DATA_WIDTH-1:0]   arr_b_o [N],
  input  logic                    arr_valid_i,
  input  logic [C_DATA_WIDTH-1:0] arr_c_i [N*N]
);

  localparam int IW = $clog2(N);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {S_CLEAR, S_FEED, S_DRAIN, S_OUT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IW-1:0]           r_beat;
  logic [IW-1:0]           r_row;
  logic [DW-1:0]           r_drain;
  logic                    r_busy;
  logic                    r_timeout;

  logic                    w_feed;
  logic                    w_out;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic                    w_last_beat;
  logic                    w_last_row;
  logic                    w_drain_expired;
  logic [C_DATA_WIDTH-1:0] w_c2d [N][N];

  assign w_feed          = (r_state == S_FEED);
  assign w_out           = (r_state == S_OUT);
  assign w_in_fire       = w_feed & in_valid_i;
  assign w_out_fire      = w_out & out_ready_i;
  assign w_last_beat     = (r_beat == IW'(N-1));
  assign w_last_row      = (r_row == IW'(N-1));
  assign w_drain_expired = (r_state == S_DRAIN) & ~arr_valid_i & (r_drain == DW'(DRAIN_TIMEOUT-1));

  assign in_ready_o  = w_feed;
  assign arr_valid_o = w_in_fire;
  assign arr_reset_o = (r_state == S_CLEAR);
  assign out_valid_o = w_out;
  assign out_idx_o   = w_out ? r_row : '0;
  assign out_last_o  = w_out & w_last_row;
  assign done_o      = w_out_fire & w_last_row;
  assign busy_o      = r_busy;
  assign timeout_o   = r_timeout;

  // Operands reach the array only in FEED; bubbles are masked by arr_valid_o.
  for (genvar i = 0; i < N; i++) begin : g_feed
    assign arr_a_o[i] = w_feed ? in_a_i[i] : '0;
    assign arr_b_o[i] = w_feed ? in_b_i[i] : '0;
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      assign w_c2d[r][j] = arr_c_i[r*N + j];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    assign out_row_o[j] = w_out ? w_c2d[r_row][j] : '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (w_in_fire && w_last_beat) w_next = S_DRAIN;
      S_DRAIN: begin
        if (arr_valid_i)          w_next = S_OUT;
        else if (w_drain_expired) w_next = S_CLEAR;
      end
      S_OUT:   if (w_out_fire && w_last_row) w_next = S_CLEAR;
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_beat    <= '0;
      r_row     <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_beat <= '0;
      end else if (w_in_fire) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end

      if (r_state == S_DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end else begin
        r_drain <= '0;
      end

      if (!w_out) begin
        r_row <= '0;
      end else if (w_out_fire) begin
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end

      if (w_in_fire) begin
        r_busy <= 1'b1;
      end else if (done_o || w_drain_expired) begin
        r_busy <= 1'b0;
      end

      // Sticky until the next job actually starts consuming operands.
      if (w_in_fire) begin
        r_timeout <= 1'b0;
      end else if (w_drain_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

endmodule
